// File: rtl/apb_master_fifo_ctrl_if.sv
// rtl/apb_master_fifo_ctrl_if.sv - request/response and APB signal bundle for the APB master controller
interface apb_master_fifo_ctrl_if #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int NUM_SLV = 3
);
   logic               req_valid;
   logic               req_ready;
   logic               req_write;
   logic [ADDR_W-1:0]  req_addr;
   logic [DATA_W-1:0]  req_wdata;
   logic [NUM_SLV-1:0] req_sel;
   logic               rsp_valid;
   logic               rsp_write;
   logic [DATA_W-1:0]  rsp_rdata;
   logic               rsp_err;
   logic               rsp_tout;
   logic [NUM_SLV-1:0] Pselx;
   logic               Penable;
   logic               Pwrite;
   logic [ADDR_W-1:0]  Paddr;
   logic [DATA_W-1:0]  Pwdata;
   logic [DATA_W-1:0]  Prdata;
   logic               Pready;
   logic               Pslverr;

   modport master (
      input  req_valid, req_write, req_addr, req_wdata, req_sel, Prdata, Pready, Pslverr,
      output req_ready, rsp_valid, rsp_write, rsp_rdata, rsp_err, rsp_tout,
             Pselx, Penable, Pwrite, Paddr, Pwdata
   );

   modport slave (
      output req_valid, req_write, req_addr, req_wdata, req_sel, Prdata, Pready, Pslverr,
      input  req_ready, rsp_valid, rsp_write, rsp_rdata, rsp_err, rsp_tout,
             Pselx, Penable, Pwrite, Paddr, Pwdata
   );
endinterface

// File: rtl/apb_master_fifo_ctrl.sv
// rtl/apb_master_fifo_ctrl.sv - queued APB master: request FIFO feeding SETUP/ACCESS cycles with wait, error and timeout handling
module apb_master_fifo_ctrl #(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int NUM_SLV    = 3,
   parameter int FIFO_DEPTH = 4,
   parameter int TIMEOUT    = 16
) (
   input logic                   Hclk,
   input logic                   Hreset,
   apb_master_fifo_ctrl_if.master bus
);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int WT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

   typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_DECERR} state_t;

   logic               fifo_write [FIFO_DEPTH];
   logic [ADDR_W-1:0]  fifo_addr  [FIFO_DEPTH];
   logic [DATA_W-1:0]  fifo_wdata [FIFO_DEPTH];
   logic [NUM_SLV-1:0] fifo_sel   [FIFO_DEPTH];

   logic [PTR_W-1:0] wr_ptr, rd_ptr, rd_ptr_inc, ld_ptr;
   logic [CNT_W-1:0] count;
   logic             full, empty, more, push, pop, xfer_done, timed_out;
   state_t           state, state_nxt;
   logic [WT_W-1:0]  wait_cnt, wait_d;

   logic               psel_en_d;
   logic [NUM_SLV-1:0] pselx_d;
   logic               penable_d, pwrite_d;
   logic [ADDR_W-1:0]  paddr_d;
   logic [DATA_W-1:0]  pwdata_d, rsp_rdata_d;
   logic               rsp_valid_d, rsp_write_d, rsp_err_d, rsp_tout_d;

   assign full          = (count == CNT_W'(FIFO_DEPTH));
   assign empty         = (count == '0);
   assign more          = (count > CNT_W'(1));
   assign bus.req_ready = !full;
   assign push          = bus.req_valid && !full;
   assign rd_ptr_inc    = rd_ptr + PTR_W'(1);
   assign ld_ptr        = pop ? rd_ptr_inc : rd_ptr;
   assign timed_out     = (TIMEOUT > 0) && !bus.Pready &&
                          ({{(32-WT_W){1'b0}}, wait_cnt} == 32'(TIMEOUT - 1));

   always_ff @(posedge Hclk) begin
      if (push) begin
         fifo_write[wr_ptr] <= bus.req_write;
         fifo_addr[wr_ptr]  <= bus.req_addr;
         fifo_wdata[wr_ptr] <= bus.req_wdata;
         fifo_sel[wr_ptr]   <= bus.req_sel;
      end
   end

   always_ff @(posedge Hclk or posedge Hreset) begin
      if (Hreset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr_inc;
         if (push && !pop)      count <= count + CNT_W'(1);
         else if (!push && pop) count <= count - CNT_W'(1);
      end
   end

   // State and all registered outputs share one reset so a mid-transfer reset drops the bus at once.
   always_ff @(posedge Hclk or posedge Hreset) begin
      if (Hreset) begin
         state         <= S_IDLE;
         wait_cnt      <= '0;
         bus.Pselx     <= '0;
         bus.Penable   <= 1'b0;
         bus.Pwrite    <= 1'b0;
         bus.Paddr     <= '0;
         bus.Pwdata    <= '0;
         bus.rsp_valid <= 1'b0;
         bus.rsp_write <= 1'b0;
         bus.rsp_rdata <= '0;
         bus.rsp_err   <= 1'b0;
         bus.rsp_tout  <= 1'b0;
      end else begin
         state         <= state_nxt;
         wait_cnt      <= wait_d;
         bus.Pselx     <= psel_en_d ? pselx_d : '0;
         bus.Penable   <= penable_d;
         bus.Pwrite    <= pwrite_d;
         bus.Paddr     <= paddr_d;
         bus.Pwdata    <= pwdata_d;
         bus.rsp_valid <= rsp_valid_d;
         bus.rsp_write <= rsp_write_d;
         bus.rsp_rdata <= rsp_rdata_d;
         bus.rsp_err   <= rsp_err_d;
         bus.rsp_tout  <= rsp_tout_d;
      end
   end

   always_comb begin
      state_nxt = state;
      pop       = 1'b0;
      xfer_done = 1'b0;
      case (state)
         S_IDLE:   if (!empty) state_nxt = (fifo_sel[rd_ptr] != '0) ? S_SETUP : S_DECERR;
         S_SETUP:  state_nxt = S_ACCESS;
         S_ACCESS: xfer_done = bus.Pready || timed_out;
         S_DECERR: xfer_done = 1'b1;
         default:  state_nxt = S_IDLE;
      endcase
      if (xfer_done) begin
         pop = 1'b1;
         if (!more)                         state_nxt = S_IDLE;
         else if (fifo_sel[rd_ptr_inc] != '0) state_nxt = S_SETUP;
         else                               state_nxt = S_DECERR;
      end
   end

   always_comb begin
      psel_en_d   = 1'b0;
      pselx_d     = bus.Pselx;
      penable_d   = 1'b0;
      pwrite_d    = bus.Pwrite;
      paddr_d     = bus.Paddr;
      pwdata_d    = bus.Pwdata;
      wait_d      = wait_cnt;
      rsp_valid_d = 1'b0;
      rsp_write_d = 1'b0;
      rsp_rdata_d = '0;
      rsp_err_d   = 1'b0;
      rsp_tout_d  = 1'b0;
      case (state_nxt)
         S_SETUP: begin
            psel_en_d = 1'b1;
            pselx_d   = fifo_sel[ld_ptr];
            pwrite_d  = fifo_write[ld_ptr];
            paddr_d   = fifo_addr[ld_ptr];
            pwdata_d  = fifo_wdata[ld_ptr];
         end
         S_ACCESS: begin
            psel_en_d = 1'b1;
            penable_d = 1'b1;
            wait_d    = (state == S_ACCESS) ? wait_cnt + WT_W'(1) : '0;
         end
         default: ;
      endcase
      if (xfer_done && state == S_ACCESS) begin
         rsp_valid_d = 1'b1;
         rsp_write_d = bus.Pwrite;
         rsp_err_d   = !bus.Pready || bus.Pslverr;
         rsp_tout_d  = !bus.Pready;
         if (bus.Pready && !bus.Pslverr && !bus.Pwrite) rsp_rdata_d = bus.Prdata;
      end else if (xfer_done) begin
         rsp_valid_d = 1'b1;
         rsp_write_d = fifo_write[rd_ptr];
         rsp_err_d   = 1'b1;
      end
   end
endmodule

// File: doc/apb_master_fifo_ctrl.md
# apb_master_fifo_ctrl

Parametrised APB master controller for the AHB-to-APB bridge. It accepts transfer requests from the AHB slave interface into a FIFO of configurable depth, so up to that many writes and reads can be posted. It runs them in order as APB SETUP/ACCESS cycles to one of NUM_SLV peripherals and returns one response per transfer. Over the previous controller it adds:
- parametrised widths and slave count
- request queueing
- PREADY wait states
- PSLVERR propagation
- decode-error handling
- an ACCESS-phase timeout

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- NUM_SLV, 3, number of APB slaves (one-hot select width)
- FIFO_DEPTH, 4, request queue entries; power of two, ≥2
- TIMEOUT, 16, maximum ACCESS cycles with Pready low before abort; 0 disables the timeout

Ports:
- Hclk  in  1  clock; single clock domain
- Hreset  in  1  asynchronous, active-high reset
- req_valid  in  1  request offered
- req_ready  out  1  queue can accept; equals !full
- req_write  in  1  1=write, 0=read
- req_addr  in  ADDR_W  transfer address
- req_wdata  in  DATA_W  write data; ignored for reads
- req_sel  in  NUM_SLV  one-hot slave select from the decoder; all-zero means no slave
- rsp_valid  out  1  one-cycle pulse per completed transfer
- rsp_write  out  1  direction of the completed transfer
- rsp_rdata  out  DATA_W  read data; 0 for writes and errors
- rsp_err  out  1  Pslverr, decode error or timeout
- rsp_tout  out  1  error was a timeout
- Pselx  out  NUM_SLV  APB select
- Penable  out  1  APB enable
- Pwrite  out  1  APB direction
- Paddr  out  ADDR_W  APB address
- Pwdata  out  DATA_W  APB write data
- Prdata  in  DATA_W  APB read data
- Pready  in  1  APB ready
- Pslverr  in  1  APB slave error

## Operation
- A request is pushed when req_valid && req_ready at a rising edge. Each FIFO entry holds {write, addr, wdata, sel}.
- When full, req_ready=0 and no push occurs, even if a pop happens in the same cycle.
- A simultaneous push and pop when not full keeps the count unchanged.
- Pointers are log2(FIFO_DEPTH) bits and wrap modulo the depth. The count is log2(FIFO_DEPTH)+1 bits.
- FSM states are IDLE, SETUP, ACCESS and DECERR.
- IDLE: if the FIFO is non-empty, look at the head entry:
  - sel≠0: go to SETUP and register Paddr, Pwrite, Pwdata and Pselx=sel from the head.
  - sel=0: go to DECERR.
- SETUP: Pselx=sel, Penable=0. Always go to ACCESS next cycle.
- ACCESS: Pselx held, Penable=1. Paddr, Pwrite and Pwdata stay stable throughout.
  - On an edge with Pready=1: pop the head and issue the response (rsp_err=Pslverr; rsp_rdata=Prdata for reads without error, else 0).
  - If the wait count reaches TIMEOUT with Pready still 0: pop, issue the response with rsp_err=1 and rsp_tout=1.
  - After completion, go to SETUP with the next head if the FIFO is non-empty, or to IDLE if empty.
  - A next head with sel=0 goes to DECERR instead of SETUP.
- DECERR: no APB activity. Pop, issue a response with rsp_err=1, rsp_tout=0, rsp_rdata=0. Next state follows the same rule as ACCESS completion.
- The wait counter is cleared on entry to ACCESS and increments on each ACCESS edge with Pready=0.
- Responses come out strictly in request order. Each response field is valid only while rsp_valid=1.

## Timing
- Reset: Pselx=0, Penable=0, Pwrite=0, Paddr=0, Pwdata=0, rsp_valid=0, rsp_write=0, rsp_rdata=0, rsp_err=0, rsp_tout=0. FIFO empty, so req_ready=1. State IDLE, counter 0.
- Reset asserted mid-transfer drops Pselx and Penable immediately (asynchronous) and discards all queued entries with no responses.
- All outputs are registered except req_ready, which is combinational from the count.
- Zero-wait latency, with the push at edge E0 into an empty FIFO in IDLE:
  - SETUP from E1
  - ACCESS from E2
  - Pready sampled at E3
  - rsp_valid high from E3 to E4
- Back-to-back transfers: the next SETUP starts at the same edge that completes the previous ACCESS, giving 2 cycles per zero-wait transfer. There is no idle cycle between transfers.
- In IDLE, Pselx=0 and Penable=0; Paddr, Pwrite and Pwdata hold their last values.
- Penable never rises without Pselx already having been high for one SETUP cycle.

## Test plan
- Single write, addr 0x0000_0010, data 0xDEADBEEF, sel=3'b010, Pready tied 1:
  - SETUP after E1, ACCESS after E2
  - rsp_valid for one cycle after E3 with rsp_write=1, rsp_err=0
- Four back-to-back reads to sel=3'b001 with Prdata=0x11, 0x22, 0x33, 0x44:
  - req_ready=0 once 4 are queued
  - responses arrive in order with those rdata values, 2 cycles apart
- Read with Pready held low for 3 ACCESS cycles, then Pready=1 with Pslverr=1:
  - Paddr and Penable stable throughout
  - rsp_err=1, rsp_rdata=0
- Pready never asserted, TIMEOUT=16:
  - abort after 16 ACCESS cycles with rsp_err=1, rsp_tout=1
  - the next queued request then starts SETUP
- Request with sel=0 queued between two valid writes:
  - Pselx stays 0 for the middle entry
  - its response has rsp_err=1, rsp_tout=0, and order is preserved
- Hreset pulsed during ACCESS with 3 entries queued:
  - Pselx and Penable are 0 immediately
  - no rsp_valid; req_ready=1
  - the next request behaves as from reset
